// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, per-frame row capture, debounced press/release FSM.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse o_Key_Valid every REPEAT_FRAMES frames while held.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned DEBOUNCE_CNT  = 4,
  parameter int unsigned REPEAT_FRAMES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_Row,
  output logic [3:0] o_Col,
  output logic [3:0] o_Key_Code,
  output logic       o_Key_Valid,
  output logic       o_Key_Held
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [3:0] DebTarget = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

  logic [3:0]        row_meta_q, row_sync_q;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [1:0]        col_q, col_d;
  logic              acc_hit_q, acc_hit_d;
  logic [3:0]        acc_code_q, acc_code_d;
  state_e            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d, cnt_inc;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;

  logic       dwell_last, frame_end, col_hit, frame_hit;
  logic [1:0] row_idx;
  logic [3:0] frame_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= i_Row;
      row_sync_q <= row_meta_q;
    end
  end

  // Scan timing and per-frame capture of the first low row in scan order.
  always_comb begin
    dwell_last = (dwell_q == DwellLast);
    frame_end  = dwell_last && (col_q == 2'd3);
    col_hit    = ~&row_sync_q;
    if (!row_sync_q[0])      row_idx = 2'd0;
    else if (!row_sync_q[1]) row_idx = 2'd1;
    else if (!row_sync_q[2]) row_idx = 2'd2;
    else                     row_idx = 2'd3;
    frame_hit  = acc_hit_q | col_hit;
    frame_code = acc_hit_q ? acc_code_q : {row_idx, col_q};

    dwell_d    = dwell_last ? '0 : dwell_q + 1'b1;
    col_d      = dwell_last ? col_q + 2'd1 : col_q;
    acc_hit_d  = acc_hit_q;
    acc_code_d = acc_code_q;
    if (frame_end) begin
      acc_hit_d  = 1'b0;
      acc_code_d = 4'h0;
    end else if (dwell_last && !acc_hit_q && col_hit) begin
      acc_hit_d  = 1'b1;
      acc_code_d = {row_idx, col_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q    <= '0;
      col_q      <= 2'd0;
      acc_hit_q  <= 1'b0;
      acc_code_q <= 4'h0;
    end else begin
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      acc_hit_q  <= acc_hit_d;
      acc_code_q <= acc_code_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = (REPEAT_FRAMES < 2) ? 1 : $clog2(REPEAT_FRAMES + 1);
  localparam logic [RepW-1:0] RepTarget = RepW'(REPEAT_FRAMES);
  logic [RepW-1:0] rep_q, rep_d, rep_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    cnt_inc = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
    rep_inc = rep_q + 1'b1;
`endif
    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (frame_hit) begin
            cand_d = frame_code;
            if (DebTarget <= 4'd1) begin
              state_d = StPressed;
              code_d  = frame_code;
              cnt_d   = 4'd0;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              state_d = StDebounce;
              cnt_d   = 4'd1;
            end
          end
        end
        StDebounce: begin
          if (!frame_hit) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end else if (frame_code != cand_q) begin
            cand_d = frame_code;
            cnt_d  = 4'd1;
          end else if (cnt_inc >= DebTarget) begin
            state_d = StPressed;
            code_d  = cand_q;
            cnt_d   = 4'd0;
            valid_d = 1'b1;
            held_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StPressed: begin
          if (!frame_hit) begin
            if (DebTarget <= 4'd1) begin
              state_d = StIdle;
              cnt_d   = 4'd0;
              held_d  = 1'b0;
            end else begin
              state_d = StRelease;
              cnt_d   = 4'd1;
            end
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_inc == RepTarget) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_inc;
            end
`endif
          end
        end
        StRelease: begin
          if (frame_hit) begin
            state_d = StPressed;
            cnt_d   = 4'd0;
          end else if (cnt_inc >= DebTarget) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    if (state_d != StPressed) rep_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cand_q  <= 4'h0;
      cnt_q   <= 4'd0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign o_Col       = ~(4'b0001 << col_q);
  assign o_Key_Code  = code_q;
  assign o_Key_Valid = valid_q;
  assign o_Key_Held  = held_q;

endmodule
